// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencing controller for the FIR engine (start/done handshake, per-sample MAC schedule).
// Define FIR_CTRL_TLAST_CHECK_EN to build the tlast/length consistency check that drives err_tlast.
module fir_ctrl #(
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_req,
    input  logic [pDATA_WIDTH-1:0]       cfg_data_length,
    input  logic                         done_clr,
    input  logic                         in_hs,
    input  logic                         axis_finish,
    input  logic                         out_hs,
    output logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         outfinish,
    output logic                         mac_en,
    output logic                         acc_clr,
    output logic [$clog2(Tape_Num)-1:0]  tap_idx,
    output logic                         sm_tvalid,
    output logic                         sm_tlast,
    output logic                         err_tlast
);

    localparam int                     TAP_W    = $clog2(Tape_Num);
    localparam logic [TAP_W-1:0]       LAST_TAP = TAP_W'(Tape_Num - 1);
    localparam logic [pDATA_WIDTH-1:0] ONE      = pDATA_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d;
    logic [pDATA_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [pDATA_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [TAP_W-1:0]       tap_q, tap_d;
    logic                   busy_q, busy_d;
    logic                   pending_q, pending_d;
    logic                   ap_start_q, ap_start_d;
    logic                   ap_idle_q, ap_idle_d;
    logic                   ap_done_q, ap_done_d;
    logic                   acc_clr_q, acc_clr_d;

    logic accept;
    logic out_take;
    logic run_end;
    logic run_start;

    // A sample is only taken when the engine is free; in_hs while busy/pending is dropped.
    assign accept    = (state_q == S_RUN) && in_hs && !busy_q && !pending_q;
    assign out_take  = (state_q == S_RUN) && out_hs && pending_q;
    assign run_end   = out_take && ((out_cnt_q + ONE) == len_q);
    assign run_start = (state_q == S_IDLE) && start_req && (cfg_data_length != '0);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        tap_d      = tap_q;
        busy_d     = busy_q;
        pending_d  = pending_q;
        ap_start_d = 1'b0;
        ap_idle_d  = ap_idle_q;
        ap_done_d  = ap_done_q;
        acc_clr_d  = accept;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (run_start) begin
                        state_d    = S_RUN;
                        len_d      = cfg_data_length;
                        in_cnt_d   = '0;
                        out_cnt_d  = '0;
                        ap_start_d = 1'b1;
                        ap_idle_d  = 1'b0;
                    end else begin
                        // Zero-length run completes immediately without starting the input stage.
                        state_d   = S_DONE;
                        ap_done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    busy_d   = 1'b1;
                    tap_d    = '0;
                    in_cnt_d = in_cnt_q + ONE;
                end
                if (busy_q) begin
                    if (tap_q == LAST_TAP) begin
                        busy_d    = 1'b0;
                        pending_d = 1'b1;
                        tap_d     = '0;
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
                if (out_take) begin
                    pending_d = 1'b0;
                    out_cnt_d = out_cnt_q + ONE;
                    if (run_end) begin
                        state_d   = S_DONE;
                        ap_done_d = 1'b1;
                        ap_idle_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (done_clr) begin
                    state_d   = S_IDLE;
                    ap_done_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                ap_idle_d = 1'b1;
                ap_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            tap_q      <= '0;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            ap_start_q <= 1'b0;
            ap_idle_q  <= 1'b1;
            ap_done_q  <= 1'b0;
            acc_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            tap_q      <= tap_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            ap_start_q <= ap_start_d;
            ap_idle_q  <= ap_idle_d;
            ap_done_q  <= ap_done_d;
            acc_clr_q  <= acc_clr_d;
        end
    end

    assign ap_start  = ap_start_q;
    assign ap_idle   = ap_idle_q;
    assign ap_done   = ap_done_q;
    assign mac_en    = busy_q;
    assign tap_idx   = tap_q;
    assign acc_clr   = acc_clr_q;
    assign sm_tvalid = pending_q;
    assign sm_tlast  = pending_q && (out_cnt_q == (len_q - ONE));
    // in_hs is combinational here so the input stage cannot accept twice in the arrival cycle.
    assign outfinish = (state_q == S_RUN) && !busy_q && !pending_q && !in_hs;

`ifdef FIR_CTRL_TLAST_CHECK_EN
    logic                   err_q, err_d;
    logic                   tlast_seen_q, tlast_seen_d;
    logic [pDATA_WIDTH-1:0] in_cnt_eff;

    always_comb begin
        err_d        = err_q;
        tlast_seen_d = tlast_seen_q;
        // Include the sample carried on this cycle's in_hs, which may be the tlast beat itself.
        in_cnt_eff   = accept ? (in_cnt_q + ONE) : in_cnt_q;
        if (run_start) begin
            err_d        = 1'b0;
            tlast_seen_d = 1'b0;
        end else if (state_q == S_RUN) begin
            if (axis_finish) begin
                tlast_seen_d = 1'b1;
                if (in_cnt_eff != len_q) begin
                    err_d = 1'b1;
                end
            end
            if (run_end && !tlast_seen_q && !axis_finish) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q        <= 1'b0;
            tlast_seen_q <= 1'b0;
        end else begin
            err_q        <= err_d;
            tlast_seen_q <= tlast_seen_d;
        end
    end

    assign err_tlast = err_q;
`else
    logic unused_axis_finish;
    assign unused_axis_finish = axis_finish;
    assign err_tlast          = 1'b0;
`endif

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencing controller for the FIR engine. Takes the software start request and data length, issues the `ap_start` pulse to the AXI-Stream input stage, and schedules one `Tape_Num`-cycle MAC pass per accepted sample. It drives `outfinish` back to the input stage so the next sample is held off until the previous result has left. It counts results against the programmed length, raises `sm_tlast` and `ap_done`, and reports `ap_idle` to the configuration register file.

## Interface

Parameters:
- `pDATA_WIDTH`, 32 — width of `cfg_data_length` and both sample counters.
- `Tape_Num`, 11 — taps per sample; sets MAC cycles per sample and the `tap_idx` range.

Ports:
- `clk` — input, 1 — single clock for all state.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `start_req` — input, 1 — one-cycle strobe from a register-file write of ap_start=1.
- `cfg_data_length` — input, pDATA_WIDTH — number of samples in the run; sampled on start.
- `done_clr` — input, 1 — one-cycle strobe from a register-file read of ap_done.
- `in_hs` — input, 1 — sample presented to the datapath this cycle (the input stage's `strm_valid`).
- `axis_finish` — input, 1 — the input stage accepted the tlast beat.
- `out_hs` — input, 1 — result accepted downstream (`sm_tvalid & sm_tready`).
- `ap_start` — output, 1 — one-cycle start pulse to the input stage.
- `ap_idle` — output, 1 — engine idle.
- `ap_done` — output, 1 — run complete; sticky until `done_clr`.
- `outfinish` — output, 1 — input stage may accept the next sample.
- `mac_en` — output, 1 — MAC step enable.
- `acc_clr` — output, 1 — clear accumulator; coincides with tap 0.
- `tap_idx` — output, $clog2(Tape_Num) — tap/coefficient address for this MAC step.
- `sm_tvalid` — output, 1 — result valid.
- `sm_tlast` — output, 1 — this result is the last of the run.
- `err_tlast` — output, 1 — tlast/length mismatch; sticky.

## Operation

States:
- IDLE → RUN on `start_req` with a nonzero sampled length. Latch the length and clear both counters and `err_tlast`.
- IDLE → DONE on `start_req` with length 0. No `ap_start` pulse is issued.
- RUN → DONE on `out_hs` when `out_cnt + 1 == len`.
- DONE → IDLE on `done_clr`.

Rules:
- `ap_start` is a registered pulse, high exactly in the first cycle of RUN.
- `ap_idle` = 1 in IDLE and DONE. `ap_done` = 1 only in DONE.
- `start_req` outside IDLE is ignored. `done_clr` outside DONE is ignored.
- Per-sample schedule:
  - `in_hs` in RUN while not busy and no result pending sets busy.
  - The next `Tape_Num` cycles assert `mac_en` with `tap_idx` counting 0..Tape_Num-1. `acc_clr` is high on tap 0 only.
  - After the last tap, busy clears and pending sets. `sm_tvalid` stays high while pending.
  - `out_hs` clears pending and increments `out_cnt`.
- `sm_tlast` = `sm_tvalid` and `out_cnt == len-1`.
- `outfinish` = RUN & ~busy & ~pending & ~`in_hs`. The `in_hs` term is combinational, so it blocks a second accept in the arrival cycle.
- `in_hs` while busy or pending is a protocol violation. It is ignored and does not count.
- `in_cnt` increments on each counted `in_hs`.
- Counters are pDATA_WIDTH bits, unsigned, with no wrap. The length compare ends the run before any wrap.
- Reset mid-run returns to IDLE and clears all state.

## Timing

Reset values:
- `ap_idle` = 1.
- All other outputs = 0, `tap_idx` = 0.

Cycle-level behaviour:
- `start_req` at cycle c → `ap_start` = 1 and `ap_idle` = 0 at c+1.
- `in_hs` at t → `mac_en` high at t+1..t+Tape_Num, with `tap_idx` = k at t+1+k.
- `sm_tvalid` rises at t+Tape_Num+1.
- `outfinish` is low from t through the `out_hs` cycle and high again the cycle after.
- Final `out_hs` at u → `ap_done` = 1 and `ap_idle` = 1 at u+1. `sm_tvalid` = 0 at u+1.
- `done_clr` at d → `ap_done` = 0 at d+1.

## Configuration

- `FIR_CTRL_TLAST_CHECK_EN` defined:
  - `err_tlast` sets when `axis_finish` arrives with `in_cnt` ≠ len, counting the `in_hs` that carries it.
  - It also sets when `in_cnt` reaches len with no `axis_finish` by the DONE transition.
  - The run still ends on the length count.
- Not defined: `err_tlast` is tied to 0 and the check logic is absent.

## Test plan

- Reset, then `Tape_Num`=11, len=3, three samples each with immediate `out_hs` → 11 `mac_en` cycles per sample, `tap_idx` 0..10. `sm_tlast` on the 3rd result only. `ap_done`=1 the cycle after the 3rd `out_hs`.
- `sm_tready` held low for 5 cycles on result 1 → `sm_tvalid` held, `outfinish` stays 0, and no `mac_en` runs until the cycle after `out_hs`.
- `start_req` with len=0 → DONE next cycle, no `ap_start` pulse. `done_clr` → `ap_idle`=1, `ap_done`=0.
- `start_req` and `done_clr` while in RUN → no effect on state or counters. A second `in_hs` during busy → ignored and `in_cnt` unchanged.
- `rst_n` asserted on tap 5 of sample 2 → next cycle `ap_idle`=1, `mac_en`=0, `sm_tvalid`=0. A fresh run then completes normally.
- With the macro defined, len=4 and tlast on sample 3 → `err_tlast`=1 and the run still completes after 4 results. Without the macro → `err_tlast`=0.
